// File: rtl/tl_rx_cpl_buffer_ptr_ctrl_pkg.sv
// Shared constants and helpers for the RX completion buffer pointer control.
// The read-control bus field positions here are also decoded by the
// completion control block and must stay in step with it.
package tl_rx_cpl_buffer_ptr_ctrl_pkg;

    localparam int HDR_DEPTH         = 16;
    localparam int DATA_DEPTH        = 64;
    localparam int R_CTRL_BUS_WIDTH  = 5;
    localparam int MAX_WR_INC        = 4;

    localparam int HDR_INC_BIT       = 4;
    localparam int DATA_INC_BIT      = 3;
    localparam int INC_VAL_MSB       = 2;
    localparam int INC_VAL_W         = INC_VAL_MSB + 1;

    localparam int DW_PER_DATA_ENTRY = 8;
    localparam int DW_PER_CREDIT     = 4;
    localparam int CREDITS_PER_ENTRY = DW_PER_DATA_ENTRY / DW_PER_CREDIT;

    localparam int HDR_AW            = $clog2(HDR_DEPTH);
    localparam int DATA_AW           = $clog2(DATA_DEPTH);
    localparam int DATA_PW           = DATA_AW + 1;
    localparam int WR_INC_W          = $clog2(MAX_WR_INC) + 1;
    localparam int DATA_CREDIT_W     = 4;

    typedef struct packed {
        logic                 hdr_inc_en;
        logic                 data_inc_en;
        logic [INC_VAL_W-1:0] data_inc_value;
    } r_ctrl_t;

    function automatic r_ctrl_t decode_r_ctrl(input logic [R_CTRL_BUS_WIDTH-1:0] bus);
        r_ctrl_t c;
        c.hdr_inc_en     = bus[HDR_INC_BIT];
        c.data_inc_en    = bus[DATA_INC_BIT];
        c.data_inc_value = bus[INC_VAL_MSB:0];
        return c;
    endfunction

    // Each data entry holds 8 DW, i.e. two 4-DW flow-control credits.
    function automatic logic [DATA_CREDIT_W-1:0] data_credits(input logic [INC_VAL_W-1:0] n);
        return DATA_CREDIT_W'(n) * DATA_CREDIT_W'(CREDITS_PER_ENTRY);
    endfunction

endpackage

// File: rtl/tl_rx_cpl_ptr_pair.sv
// Generic write/read pointer pair for a power-of-two circular array.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// count/free/empty/full are combinational from the registered pointers.
module tl_rx_cpl_ptr_pair #(
    parameter int  DEPTH = 16,
    parameter int  INC_W = 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [INC_W-1:0] i_wr_inc,
    input  logic             i_rd_en,
    input  logic [INC_W-1:0] i_rd_inc,
    output logic [AW-1:0]    o_wr_addr,
    output logic [AW-1:0]    o_rd_addr,
    output logic [PW-1:0]    o_count,
    output logic [PW-1:0]    o_free,
    output logic             o_empty,
    output logic             o_full
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Advance each pointer by its increment; wrap is natural modulo 2*DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_wr_en) wr_ptr <= wr_ptr + PW'(i_wr_inc);
            if (i_rd_en) rd_ptr <= rd_ptr + PW'(i_rd_inc);
        end
    end

    assign o_wr_addr = wr_ptr[AW-1:0];
    assign o_rd_addr = rd_ptr[AW-1:0];
    assign o_count   = wr_ptr - rd_ptr;
    assign o_free    = PW'(DEPTH) - o_count;
    assign o_empty   = (wr_ptr == rd_ptr);
    assign o_full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/tl_rx_cpl_buffer_ptr_ctrl.sv
// Read/write pointer manager for one VC's RX completion buffer.
// Decodes the read-control bus, drives empty/full/free status and returns
// freed header/data credits one cycle after each read increment.
// Optional build macro TL_RX_CPL_PTR_ERR_CHK_EN: drop illegal increments and
// expose a sticky o_ptr_err flag. Without it increments are applied as given.
module tl_rx_cpl_buffer_ptr_ctrl
    import tl_rx_cpl_buffer_ptr_ctrl_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_hdr_wr_en,
    input  logic                        i_data_wr_en,
    input  logic [WR_INC_W-1:0]         i_data_wr_inc,
    input  logic [R_CTRL_BUS_WIDTH-1:0] i_r_completion_ctrl,
    output logic [HDR_AW-1:0]           o_hdr_wr_addr,
    output logic [DATA_AW-1:0]          o_data_wr_addr,
    output logic [HDR_AW-1:0]           o_hdr_rd_addr,
    output logic [DATA_AW-1:0]          o_data_rd_addr,
    output logic [1:0]                  o_cpl_r_empty_flags,
    output logic                        o_hdr_full,
    output logic [DATA_PW-1:0]          o_data_free,
    output logic                        o_hdr_credit_rtn,
`ifdef TL_RX_CPL_PTR_ERR_CHK_EN
    output logic [DATA_CREDIT_W-1:0]    o_data_credit_rtn,
    output logic                        o_ptr_err
`else
    output logic [DATA_CREDIT_W-1:0]    o_data_credit_rtn
`endif
);

    r_ctrl_t              r_ctrl;
    logic                 hdr_wr_en;
    logic                 hdr_rd_en;
    logic                 data_wr_en;
    logic                 data_rd_en;
    logic                 hdr_empty;
    logic                 hdr_full;
    logic                 data_empty;
    logic                 data_full;
    logic [HDR_AW:0]      hdr_count;
    logic [HDR_AW:0]      hdr_free;
    logic [DATA_PW-1:0]   data_count;
    logic [DATA_PW-1:0]   data_free;
    logic                 unused_status;

    // Decode the read-control bus into its fields.
    always_comb begin
        r_ctrl = decode_r_ctrl(i_r_completion_ctrl);
    end

`ifdef TL_RX_CPL_PTR_ERR_CHK_EN
    logic [DATA_PW-1:0] data_avail;
    logic               ptr_err;

    // Gate each increment by legality; a same-cycle legal write counts as
    // available to the read so simultaneous traffic still nets out.
    always_comb begin
        hdr_wr_en  = i_hdr_wr_en && !hdr_full;
        hdr_rd_en  = r_ctrl.hdr_inc_en && (!hdr_empty || hdr_wr_en);
        data_wr_en = i_data_wr_en && (DATA_PW'(i_data_wr_inc) <= data_free);
        data_avail = data_count + (data_wr_en ? DATA_PW'(i_data_wr_inc) : '0);
        data_rd_en = r_ctrl.data_inc_en && (DATA_PW'(r_ctrl.data_inc_value) <= data_avail);
    end

    // Sticky error on any dropped increment; only reset clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_err <= 1'b0;
        end else if ((i_hdr_wr_en && !hdr_wr_en) || (r_ctrl.hdr_inc_en && !hdr_rd_en) ||
                     (i_data_wr_en && !data_wr_en) || (r_ctrl.data_inc_en && !data_rd_en)) begin
            ptr_err <= 1'b1;
        end
    end

    assign o_ptr_err = ptr_err;
`else
    // Upstream guarantees legality, so increments pass straight through.
    always_comb begin
        hdr_wr_en  = i_hdr_wr_en;
        hdr_rd_en  = r_ctrl.hdr_inc_en;
        data_wr_en = i_data_wr_en;
        data_rd_en = r_ctrl.data_inc_en;
    end
`endif

    tl_rx_cpl_ptr_pair #(
        .DEPTH (HDR_DEPTH),
        .INC_W (1)
    ) u_hdr_ptr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (hdr_wr_en),
        .i_wr_inc  (1'b1),
        .i_rd_en   (hdr_rd_en),
        .i_rd_inc  (1'b1),
        .o_wr_addr (o_hdr_wr_addr),
        .o_rd_addr (o_hdr_rd_addr),
        .o_count   (hdr_count),
        .o_free    (hdr_free),
        .o_empty   (hdr_empty),
        .o_full    (hdr_full)
    );

    tl_rx_cpl_ptr_pair #(
        .DEPTH (DATA_DEPTH),
        .INC_W (INC_VAL_W)
    ) u_data_ptr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (data_wr_en),
        .i_wr_inc  (i_data_wr_inc),
        .i_rd_en   (data_rd_en),
        .i_rd_inc  (r_ctrl.data_inc_value),
        .o_wr_addr (o_data_wr_addr),
        .o_rd_addr (o_data_rd_addr),
        .o_count   (data_count),
        .o_free    (data_free),
        .o_empty   (data_empty),
        .o_full    (data_full)
    );

    // Status the reader and writer consume but this level does not otherwise need.
    assign unused_status = ^{hdr_count, hdr_free, data_full, data_count};

    assign o_cpl_r_empty_flags = {hdr_empty, data_empty};
    assign o_hdr_full          = hdr_full;
    assign o_data_free         = data_free;

    // Register freed credits so they appear one cycle after the read increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hdr_credit_rtn  <= 1'b0;
            o_data_credit_rtn <= '0;
        end else begin
            o_hdr_credit_rtn  <= hdr_rd_en;
            o_data_credit_rtn <= data_rd_en ? data_credits(r_ctrl.data_inc_value) : '0;
        end
    end

endmodule

// File: tb/tb_tl_rx_cpl_buffer_ptr_ctrl.sv
// Directed scoreboard bench for tl_rx_cpl_buffer_ptr_ctrl.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_tl_rx_cpl_buffer_ptr_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_hdr_wr_en = 1'b0;
    logic       i_data_wr_en = 1'b0;
    logic [2:0] i_data_wr_inc = 3'd0;
    logic [4:0] i_r_completion_ctrl = 5'd0;
    logic [3:0] o_hdr_wr_addr;
    logic [5:0] o_data_wr_addr;
    logic [3:0] o_hdr_rd_addr;
    logic [5:0] o_data_rd_addr;
    logic [1:0] o_cpl_r_empty_flags;
    logic       o_hdr_full;
    logic [6:0] o_data_free;
    logic       o_hdr_credit_rtn;
    logic [3:0] o_data_credit_rtn;
`ifdef TL_RX_CPL_PTR_ERR_CHK_EN
    logic       o_ptr_err;
`endif

    tl_rx_cpl_buffer_ptr_ctrl dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_hdr_wr_en         (i_hdr_wr_en),
        .i_data_wr_en        (i_data_wr_en),
        .i_data_wr_inc       (i_data_wr_inc),
        .i_r_completion_ctrl (i_r_completion_ctrl),
        .o_hdr_wr_addr       (o_hdr_wr_addr),
        .o_data_wr_addr      (o_data_wr_addr),
        .o_hdr_rd_addr       (o_hdr_rd_addr),
        .o_data_rd_addr      (o_data_rd_addr),
        .o_cpl_r_empty_flags (o_cpl_r_empty_flags),
        .o_hdr_full          (o_hdr_full),
        .o_data_free         (o_data_free),
        .o_hdr_credit_rtn    (o_hdr_credit_rtn),
`ifdef TL_RX_CPL_PTR_ERR_CHK_EN
        .o_data_credit_rtn   (o_data_credit_rtn),
        .o_ptr_err           (o_ptr_err)
`else
        .o_data_credit_rtn   (o_data_credit_rtn)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         hw;
        int         dw;
        int         hr;
        int         dr;
        int         flags;
        int         full;
        int         free;
        int         err;
    } exp_t;

    typedef struct {
        int hdr;
        int data;
        int cyc;
    } crd_t;

    exp_t exp_q[$];
    crd_t crd_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare queued state expectations, and match every credit pulse
    // against the oldest queued credit (value and cycle of arrival).
    exp_t e;
    crd_t c;
    always @(negedge i_clk) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, "/hdr_wr_addr"},  int'(o_hdr_wr_addr),       e.hw);
            chk({e.name, "/data_wr_addr"}, int'(o_data_wr_addr),      e.dw);
            chk({e.name, "/hdr_rd_addr"},  int'(o_hdr_rd_addr),       e.hr);
            chk({e.name, "/data_rd_addr"}, int'(o_data_rd_addr),      e.dr);
            chk({e.name, "/empty_flags"},  int'(o_cpl_r_empty_flags), e.flags);
            chk({e.name, "/hdr_full"},     int'(o_hdr_full),          e.full);
            chk({e.name, "/data_free"},    int'(o_data_free),         e.free);
`ifdef TL_RX_CPL_PTR_ERR_CHK_EN
            chk({e.name, "/ptr_err"},      int'(o_ptr_err),           e.err);
`endif
        end
        if (o_hdr_credit_rtn || (o_data_credit_rtn != 4'd0)) begin
            if (crd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL credit_spurious: got hdr=%0d data=%0d at cycle %0d, expected none",
                         o_hdr_credit_rtn, o_data_credit_rtn, cyc);
            end else begin
                c = crd_q.pop_front();
                chk("credit_hdr",   int'(o_hdr_credit_rtn),  c.hdr);
                chk("credit_data",  int'(o_data_credit_rtn), c.data);
                chk("credit_cycle", cyc,                     c.cyc);
            end
        end
    end

    task automatic expect_st(input string name, input int hw, input int dw, input int hr,
                             input int dr, input int flags, input int full, input int free,
                             input int err = 0);
        exp_t x;
        x.name = name; x.hw = hw; x.dw = dw; x.hr = hr; x.dr = dr;
        x.flags = flags; x.full = full; x.free = free; x.err = err;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        i_hdr_wr_en         = 1'b0;
        i_data_wr_en        = 1'b0;
        i_data_wr_inc       = 3'd0;
        i_r_completion_ctrl = 5'd0;
    endtask

    // One clock of stimulus; ch/cd are the credits expected right after this edge.
    task automatic step(input logic hw, input logic dw, input logic [2:0] dinc,
                        input logic [4:0] ctrl, input int ch, input int cd);
        crd_t x;
        i_hdr_wr_en         = hw;
        i_data_wr_en        = dw;
        i_data_wr_inc       = dinc;
        i_r_completion_ctrl = ctrl;
        @(posedge i_clk);
        #1;
        idle();
        if (ch != 0 || cd != 0) begin
            x.hdr = ch; x.data = cd; x.cyc = cyc;
            crd_q.push_back(x);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        expect_st("reset", 0, 0, 0, 0, 3, 0, 64);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Traffic, then reset asserted in the middle of a write burst.
        step(1, 1, 3'd4, 5'b00000, 0, 0);
        expect_st("wr1", 1, 4, 0, 0, 0, 0, 60);
        step(1, 1, 3'd4, 5'b00000, 0, 0);
        expect_st("wr2", 2, 8, 0, 0, 0, 0, 56);
        i_hdr_wr_en = 1'b1; i_data_wr_en = 1'b1; i_data_wr_inc = 3'd4;
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        expect_st("rst_mid", 0, 0, 0, 0, 3, 0, 64);
        @(posedge i_clk);
        #1;
        expect_st("rst_hold", 0, 0, 0, 0, 3, 0, 64);
        idle();
        i_rst = 1'b0;

        // Header fill to full, then drain with per-read credits.
        for (int i = 0; i < 15; i++) step(1, 0, 3'd0, 5'b00000, 0, 0);
        expect_st("hdr_fill15", 15, 0, 0, 0, 1, 0, 64);
        step(1, 0, 3'd0, 5'b00000, 0, 0);
        expect_st("hdr_full", 0, 0, 0, 0, 1, 1, 64);
        step(0, 0, 3'd0, 5'b10000, 1, 0);
        expect_st("hdr_rd1", 0, 0, 1, 0, 1, 0, 64);
        for (int i = 0; i < 14; i++) step(0, 0, 3'd0, 5'b10000, 1, 0);
        expect_st("hdr_rd15", 0, 0, 15, 0, 1, 0, 64);
        step(0, 0, 3'd0, 5'b10000, 1, 0);
        expect_st("hdr_drained", 0, 0, 0, 0, 3, 0, 64);

        // Move data pointers to 62, then write across the wrap.
        for (int i = 0; i < 15; i++) step(0, 1, 3'd4, 5'b00000, 0, 0);
        step(0, 1, 3'd2, 5'b00000, 0, 0);
        expect_st("data_fill62", 0, 62, 0, 0, 2, 0, 2);
        for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 5'b01111, 0, 14);
        step(0, 0, 3'd0, 5'b01110, 0, 12);
        expect_st("data_drain62", 0, 62, 0, 62, 3, 0, 64);
        step(0, 1, 3'd4, 5'b00000, 0, 0);
        expect_st("data_wrap_wr", 0, 2, 0, 62, 2, 0, 60);
        step(0, 0, 3'd0, 5'b01100, 0, 8);
        expect_st("data_wrap_rd", 0, 2, 0, 2, 3, 0, 64);

        // Enabled with value 0, and value without enable: neither moves.
        step(0, 0, 3'd0, 5'b01000, 0, 0);
        expect_st("inc_val0", 0, 2, 0, 2, 3, 0, 64);
        step(0, 0, 3'd0, 5'b00111, 0, 0);
        expect_st("inc_dis", 0, 2, 0, 2, 3, 0, 64);

        // Simultaneous write 2 and read 5 on a count of 3.
        step(0, 1, 3'd3, 5'b00000, 0, 0);
        expect_st("sim_pre", 0, 5, 0, 2, 2, 0, 61);
        step(0, 1, 3'd2, 5'b01101, 0, 10);
        expect_st("sim", 0, 7, 0, 7, 3, 0, 64);

        // Full completion read: header +1 and data +5 together.
        step(1, 1, 3'd4, 5'b00000, 0, 0);
        expect_st("cpl_pre1", 1, 11, 0, 7, 0, 0, 60);
        step(0, 1, 3'd1, 5'b00000, 0, 0);
        expect_st("cpl_pre2", 1, 12, 0, 7, 0, 0, 59);
        step(0, 0, 3'd0, 5'b11101, 1, 10);
        expect_st("cpl_rd", 1, 12, 1, 12, 3, 0, 64);

`ifdef TL_RX_CPL_PTR_ERR_CHK_EN
        step(0, 1, 3'd1, 5'b00000, 0, 0);
        expect_st("err_pre", 1, 13, 1, 12, 2, 0, 63, 0);
        step(0, 0, 3'd0, 5'b01011, 0, 0);
        expect_st("err_under", 1, 13, 1, 12, 2, 0, 63, 1);
        step(0, 0, 3'd0, 5'b01001, 0, 2);
        expect_st("err_sticky", 1, 13, 1, 13, 3, 0, 64, 1);
        step(0, 0, 3'd0, 5'b00000, 0, 0);
        i_rst = 1'b1;
        expect_st("err_rst", 0, 0, 0, 0, 3, 0, 64, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
`endif

        repeat (3) @(posedge i_clk);
        #1;
        chk("state_queue_drained",  exp_q.size(), 0);
        chk("credit_queue_drained", crd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
